// File: rtl/display_pkg.sv
// Shared definitions for the display path: page encodings, default timing
// parameters and the page rotation order. Used by the scheduler and the
// digit mux so both agree on what each content code means.
package display_pkg;

  typedef enum logic [1:0] {
    TIME24 = 2'b00,
    TIME12 = 2'b01,
    DATE   = 2'b10,
    YEAR   = 2'b11
  } content_e;

  localparam int SCAN_DIV_DEF     = 100000;
  localparam int DWELL_FRAMES_DEF = 500;

  // Page rotation order: TIME24 -> TIME12 -> DATE -> YEAR -> TIME24.
  function automatic content_e next_content(input content_e cur);
    content_e nxt;
    case (cur)
      TIME24:  nxt = TIME12;
      TIME12:  nxt = DATE;
      DATE:    nxt = YEAR;
      default: nxt = TIME24;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Display scheduler bus: button/auto-rotate requests in, page selection,
// active digit, blanking and frame strobe out.
//   master : request side (drives mode_btn, auto_en)
//   slave  : scheduler side (drives content, clk_quick, blank, frame_tick)
interface display_scheduler_if;
  import display_pkg::*;

  logic       mode_btn;
  logic       auto_en;
  content_e   content;
  logic [1:0] clk_quick;
  logic       blank;
  logic       frame_tick;

  modport master (
    output mode_btn, auto_en,
    input  content, clk_quick, blank, frame_tick
  );

  modport slave (
    input  mode_btn, auto_en,
    output content, clk_quick, blank, frame_tick
  );

endinterface

// File: rtl/display_scheduler_scan_counter.sv
// scan_counter: digit scan timebase. A prescaler counts 0..SCAN_DIV-1; the
// last count is a scan step, which advances the 2-bit digit index.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   clk_quick   : registered active digit index, 0 = rightmost
//   step        : high for the cycle where the prescaler is at terminal count
//   frame_end   : step while the last digit (index 3) is active
module scan_counter #(
  parameter int SCAN_DIV = display_pkg::SCAN_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] clk_quick,
  output logic       step,
  output logic       frame_end
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] presc;

  assign step      = (presc == CNT_W'(SCAN_DIV - 1));
  assign frame_end = step && (clk_quick == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      clk_quick <= 2'd0;
    end else if (step) begin
      presc     <= '0;
      clk_quick <= clk_quick + 2'd1;
    end else begin
      presc     <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: chooses which page the 4-digit display shows and when.
// Page changes are deferred to frame boundaries so a frame never mixes two
// pages; the frame right after a change is blanked.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of display_scheduler_if
//                (mode_btn, auto_en in; content, clk_quick, blank, frame_tick out)
//
// Page state (content register):
//   state  | meaning
//   TIME24 | 24-hour time
//   TIME12 | 12-hour time
//   DATE   | date
//   YEAR   | year
module display_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DWELL_FRAMES = DWELL_FRAMES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scheduler_if.slave  bus
);

  // Zero-width guard for DWELL_FRAMES == 1 (dwell then always expires).
  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  logic [1:0] clk_quick;
  logic       step;
  logic       frame_end;

  scan_counter #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_quick (clk_quick),
    .step      (step),
    .frame_end (frame_end)
  );

  content_e        content_q, content_d;
  logic            pending_q, pending_d;
  logic [DW_W-1:0] dwell_q,   dwell_d;
  logic            blank_q,   blank_d;
  logic            tick_q,    tick_d;

  logic frame_bnd;
  logic dwell_expire;
  logic advance;

  assign frame_bnd    = step && frame_end;
  assign dwell_expire = bus.auto_en && (dwell_q == DW_W'(DWELL_FRAMES - 1));
  // Only the registered pending flag counts, so a press landing on the
  // boundary cycle waits for the next frame.
  assign advance      = frame_bnd && (pending_q || dwell_expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      content_q <= TIME24;
      pending_q <= 1'b0;
      dwell_q   <= '0;
      blank_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      content_q <= content_d;
      pending_q <= pending_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    content_d = content_q;
    pending_d = pending_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    tick_d    = frame_bnd;

    // Presses while a request is outstanding are dropped.
    if (pending_q) begin
      if (frame_bnd) pending_d = 1'b0;
    end else if (bus.mode_btn) begin
      pending_d = 1'b1;
    end

    if (!bus.auto_en) begin
      dwell_d = '0;
    end else if (frame_bnd) begin
      dwell_d = advance ? '0 : dwell_q + 1'b1;
    end

    // Blank exactly the frame that follows a page change.
    if (frame_bnd) blank_d = advance;

    if (advance) content_d = next_content(content_q);
  end

  assign bus.content    = content_q;
  assign bus.clk_quick  = clk_quick;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;
  import display_pkg::*;

  localparam int SD = 4;
  localparam int DF = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display_scheduler_if bus ();

  display_scheduler #(.SCAN_DIV(SD), .DWELL_FRAMES(DF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // cyc = k means we are 1 time unit after the k-th edge since release.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  // Button is sampled on the next edge; cyc advances by one.
  task automatic pulse_btn();
    bus.mode_btn = 1'b1;
    tick();
    bus.mode_btn = 1'b0;
  endtask

  task automatic do_reset(input logic auto_v);
    rst_n        = 1'b0;
    bus.mode_btn = 1'b0;
    bus.auto_en  = auto_v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode_btn = 1'b0;
    bus.auto_en  = 1'b0;

    // Reset state and idle scanning
    do_reset(1'b0);
    check_val("rst_content", int'(bus.content), 0);
    check_val("rst_quick", int'(bus.clk_quick), 0);
    check_val("rst_blank", int'(bus.blank), 0);
    check_val("rst_tick", int'(bus.frame_tick), 0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      check_val("idle_quick", int'(bus.clk_quick), (k / 4) % 4);
      check_val("idle_tick", int'(bus.frame_tick), (k % 16 == 0) ? 1 : 0);
      check_val("idle_content", int'(bus.content), 0);
      check_val("idle_blank", int'(bus.blank), 0);
    end

    // Manual advance, second press while pending is ignored
    do_reset(1'b0);
    run_to(4);
    pulse_btn();
    pulse_btn();
    run_to(15);
    check_val("man_pre", int'(bus.content), 0);
    check_val("man_pre_blank", int'(bus.blank), 0);
    run_to(16);
    check_val("man_chg", int'(bus.content), 1);
    check_val("man_blank_on", int'(bus.blank), 1);
    check_val("man_tick", int'(bus.frame_tick), 1);
    run_to(31);
    check_val("man_blank_hold", int'(bus.blank), 1);
    run_to(32);
    check_val("man_blank_off", int'(bus.blank), 0);
    check_val("man_no_second", int'(bus.content), 1);
    run_to(48);
    check_val("man_stable", int'(bus.content), 1);

    // Auto rotation every 48 cycles
    do_reset(1'b1);
    run_to(47);
    check_val("auto_c0", int'(bus.content), 0);
    run_to(48);
    check_val("auto_c1", int'(bus.content), 1);
    check_val("auto_blank_on", int'(bus.blank), 1);
    run_to(64);
    check_val("auto_blank_off", int'(bus.blank), 0);
    run_to(95);
    check_val("auto_c1_hold", int'(bus.content), 1);
    run_to(96);
    check_val("auto_c2", int'(bus.content), 2);
    run_to(143);
    check_val("auto_c2_hold", int'(bus.content), 2);
    run_to(144);
    check_val("auto_c3", int'(bus.content), 3);
    run_to(191);
    check_val("auto_c3_hold", int'(bus.content), 3);
    run_to(192);
    check_val("auto_wrap", int'(bus.content), 0);

    // Press during the dwell-expiry frame: one advance only
    do_reset(1'b1);
    run_to(39);
    pulse_btn();
    run_to(47);
    check_val("coll_pre", int'(bus.content), 0);
    run_to(48);
    check_val("coll_once", int'(bus.content), 1);
    run_to(64);
    check_val("coll_no_extra", int'(bus.content), 1);
    run_to(95);
    check_val("coll_dwell_hold", int'(bus.content), 1);
    run_to(96);
    check_val("coll_next_auto", int'(bus.content), 2);

    // Press on the frame_end cycle is deferred one frame
    do_reset(1'b0);
    run_to(15);
    pulse_btn();
    check_val("edge_not_now", int'(bus.content), 0);
    check_val("edge_no_blank", int'(bus.blank), 0);
    run_to(31);
    check_val("edge_wait", int'(bus.content), 0);
    run_to(32);
    check_val("edge_applied", int'(bus.content), 1);

    // Async reset with pending set and content DATE
    do_reset(1'b0);
    run_to(2);
    pulse_btn();
    run_to(18);
    pulse_btn();
    run_to(36);
    pulse_btn();
    run_to(40);
    check_val("ar_pre_content", int'(bus.content), 2);
    check_val("ar_pre_blank", int'(bus.blank), 1);
    check_val("ar_pre_quick", int'(bus.clk_quick), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_content", int'(bus.content), 0);
    check_val("ar_quick", int'(bus.clk_quick), 0);
    check_val("ar_blank", int'(bus.blank), 0);
    check_val("ar_tick", int'(bus.frame_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_to(3);
    check_val("ar_quick_3", int'(bus.clk_quick), 0);
    run_to(4);
    check_val("ar_first_step", int'(bus.clk_quick), 1);
    run_to(16);
    check_val("ar_tick_16", int'(bus.frame_tick), 1);
    check_val("ar_pending_lost", int'(bus.content), 0);
    run_to(32);
    check_val("ar_pending_lost2", int'(bus.content), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit scan step, minimum 2.
REQ-002 Parameter DWELL_FRAMES, default 500: full scan frames per auto-rotation step, minimum 1.
REQ-003 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 mode_btn  input  1  single-cycle pulse from debounced button; requests a content advance.
REQ-006 auto_en  input  1  level; enables automatic content rotation.
REQ-007 content  output  2  display page: 00 TIME24, 01 TIME12, 10 DATE, 11 YEAR.
REQ-008 clk_quick  output  2  active digit index, 0 = rightmost.
REQ-009 blank  output  1  high = drive all digits off for the current frame.
REQ-010 frame_tick  output  1  single-cycle pulse at end of each scan frame.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; step = cycle where count == SCAN_DIV-1.
REQ-012 clk_quick SHALL increment on each step, wrapping 3 -> 0.
REQ-013 frame_end = step while clk_quick == 3; frame_tick SHALL be a registered copy, high on the cycle after frame_end.
REQ-014 mode_btn pulse SHALL set a pending flag; further pulses while pending SHALL be ignored.
REQ-015 content SHALL change only on frame_end, so a page switch never occurs mid-frame.
REQ-016 On frame_end with pending set: content <= next(content), pending cleared, dwell counter cleared.
REQ-017 next(): TIME24 -> TIME12 -> DATE -> YEAR -> TIME24.
REQ-018 With auto_en high, dwell counter SHALL increment on each frame_end; at frame_end with dwell == DWELL_FRAMES-1 content SHALL advance via next() and dwell clear.
REQ-019 Pending and dwell expiry on same frame_end: content SHALL advance exactly once; pending and dwell both clear.
REQ-020 auto_en low: dwell counter SHALL be held at 0; manual advance unaffected.
REQ-021 blank SHALL rise at the cycle following a content change and stay high for exactly one full frame (until next frame_end), then fall.
REQ-022 A mode_btn pulse on the same cycle as frame_end SHALL be held pending for the next frame_end, not applied immediately.
REQ-023 Outputs content, clk_quick, blank, frame_tick SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst_n low SHALL immediately force content=00, clk_quick=00, blank=0, frame_tick=0, prescaler=0, dwell=0, pending=0.
REQ-025 Reset asserted mid-frame or mid-dwell SHALL discard all progress; after release prescaler restarts at 0.
REQ-026 First step after reset release SHALL occur SCAN_DIV cycles after the first active clock edge.

Structure
REQ-027 Content encodings (TIME24, TIME12, DATE, YEAR) and SCAN_DIV/DWELL_FRAMES defaults SHALL live in shared package display_pkg, also used by the digit mux.
REQ-028 Prescaler plus digit index SHALL be one sub-module, scan_counter (outputs clk_quick, step, frame_end); mode/dwell/blank logic stays in display_scheduler.
REQ-029 Counter widths SHALL be derived by $clog2 of the parameters; no fixed-width literals for them.

Verification (SCAN_DIV=4, DWELL_FRAMES=3; frame = 16 cycles)
REQ-030 Reset release, idle 64 cycles -> clk_quick sequence 0,1,2,3 each held 4 cycles, frame_tick every 16 cycles, content stays 00, blank 0.
REQ-031 mode_btn pulse at cycle 5 -> content 00->01 at first frame_end, blank high for the following 16 cycles; second pulse at cycle 6 ignored.
REQ-032 auto_en=1, no button -> content advances every 48 cycles: 00,01,10,11,00.
REQ-033 auto_en=1, mode_btn pulse in frame 3 (dwell expiry frame) -> single advance at that frame_end; next auto advance 48 cycles later.
REQ-034 mode_btn pulse exactly on frame_end cycle -> content changes at the following frame_end, 16 cycles later.
REQ-035 rst_n low at cycle 40 with pending set and content=10 -> all outputs 0 asynchronously; pending lost after release.
